serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 sub  input  1  0 = A+B+cin; 1 = A-B (two's complement), sampled with start.
REQ-006 a  input  WIDTH  operand A, sampled with start.
REQ-007 b  input  WIDTH  operand B, sampled with start.
REQ-008 cin  input  1  carry-in for add, sampled with start; ignored when sub=1.
REQ-009 fa_a, fa_b, fa_cin  output  1 each  bit operands driven to the external one-bit full adder.
REQ-010 fa_s, fa_cout  input  1 each  combinational sum/carry returned by that full adder.
REQ-011 busy  output  1  high in RUN and DONE.
REQ-012 done  output  1  single-cycle pulse, result valid.
REQ-013 sum  output  WIDTH  result, held stable from done until next accepted start.
REQ-014 cout  output  1  final carry out (for sub: 1 = no borrow).
REQ-015 ovf  output  1  signed overflow of the final result.

Function
REQ-016 State machine SHALL have states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally next cycle.
REQ-017 On accepted start: latch a into A shift reg, b (or ~b when sub=1) into B shift reg, carry reg <= (sub ? 1 : cin), bit counter <= 0.
REQ-018 In RUN, fa_a = A_reg[0], fa_b = B_reg[0], fa_cin = carry reg, all register-driven (no combinational path from start/a/b to fa_*).
REQ-019 Each RUN cycle: capture fa_s into MSB of sum shift reg (shift right), carry reg <= fa_cout, shift A/B regs right by 1, counter++.
REQ-020 LSB processed first; after WIDTH RUN cycles sum holds the full WIDTH-bit result in natural bit order.
REQ-021 In the last RUN cycle (counter = WIDTH-1), ovf reg <= fa_cin XOR fa_cout; cout reg <= fa_cout.
REQ-022 Latency: start accepted at edge N -> done high for exactly the cycle after edge N+WIDTH+1... precisely: done=1 in the DONE state only, i.e. WIDTH+1 cycles after the accepting edge.
REQ-023 fa_a, fa_b, fa_cin SHALL be 0 in IDLE and DONE.
REQ-024 start while busy=1 SHALL be ignored (no restart, no operand relatch); start held high through DONE is accepted only once back in IDLE.
REQ-025 start in the IDLE cycle following DONE SHALL be accepted (back-to-back ops, WIDTH+2 cycle period).
REQ-026 sum, cout, ovf SHALL not change during RUN as visible outputs (output regs update only on RUN->DONE transition).
REQ-027 Counter width SHALL be ceil(log2(WIDTH))+1 bits; no wrap occurs before the RUN->DONE check.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, fa_a=fa_b=fa_cin=0, all internal regs 0.
REQ-029 Reset asserted mid-RUN SHALL abort the operation with no done pulse; first start after rst_n deasserts is accepted normally.
REQ-030 rst_n deassertion SHALL take effect on the next rising edge; start sampled on that same edge is ignored.

Verification (WIDTH=8, bench models fa_s/fa_cout as correct full adder)
REQ-031 a=0x5A, b=0x33, cin=0, sub=0 -> done 9 cycles after accept, sum=0x8D, cout=0, ovf=1.
REQ-032 a=0xFF, b=0x01, cin=0, sub=0 -> sum=0x00, cout=1, ovf=0; repeat with cin=1 -> sum=0x01, cout=1.
REQ-033 a=0x10, b=0x20, sub=1, cin=0 -> sum=0xF0, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-034 Pulse start again 3 cycles into RUN with different operands -> ignored, result matches first operands, exactly one done pulse.
REQ-035 rst_n low at RUN cycle 4 -> all outputs 0 at once, no done; then a=0x01,b=0x01 -> sum=0x02.
REQ-036 start held high continuously -> ops accepted every 10 cycles, each done a single-cycle pulse.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller driving an external one-bit full adder.
// Operands are shifted out LSB first, one bit per RUN cycle; the result is
// collected in a shift register and published only when the operation ends.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; fa_* held low; last result visible
// RUN   | one bit per cycle through the external full adder
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             fa_a,
   output logic             fa_b,
   output logic             fa_cin,
   input  logic             fa_s,
   input  logic             fa_cout,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, b_q, sh_q, sum_q;
   logic             carry_q, cout_q, ovf_q;
   logic [CW-1:0]    cnt_q;
   // Low for the first edge after reset release so a start already high
   // on that edge is not taken.
   logic             armed_q;
   logic             accept, last;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode plus accept / last-bit strobes
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      last    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && armed_q) begin
               accept  = 1'b1;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
               last    = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Reset-release qualifier
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) armed_q <= 1'b0;
      else        armed_q <= 1'b1;
   end

   // Operand shift registers, carry, bit counter and published result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         sh_q    <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else if (accept) begin
         a_q     <= a;
         b_q     <= sub ? ~b : b;
         carry_q <= sub ? 1'b1 : cin;
         cnt_q   <= '0;
      end else if (state_q == S_RUN) begin
         sh_q    <= {fa_s, sh_q[WIDTH-1:1]};
         a_q     <= a_q >> 1;
         b_q     <= b_q >> 1;
         carry_q <= fa_cout;
         cnt_q   <= cnt_q + CW'(1);
         if (last) begin
            // Final bit goes straight into the visible result so it is
            // complete in the same edge that enters DONE.
            sum_q  <= {fa_s, sh_q[WIDTH-1:1]};
            cout_q <= fa_cout;
            ovf_q  <= carry_q ^ fa_cout;
         end
      end
   end

   // Adder operands come only from registers and are gated off outside RUN
   always_comb begin
      fa_a   = (state_q == S_RUN) & a_q[0];
      fa_b   = (state_q == S_RUN) & b_q[0];
      fa_cin = (state_q == S_RUN) & carry_q;
   end

   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8) with a behavioural full adder.
module tb_serial_add_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         sub = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         fa_a, fa_b, fa_cin, fa_s, fa_cout;
   logic         busy, done, cout, ovf;
   logic [W-1:0] sum;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [W-1:0] last_sum = '0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[7];

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
      .cin(cin), .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin), .fa_s(fa_s),
      .fa_cout(fa_cout), .busy(busy), .done(done), .sum(sum), .cout(cout),
      .ovf(ovf)
   );

   assign fa_s    = fa_a ^ fa_b ^ fa_cin;
   assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called in the first RUN cycle; follows the op through DONE back to IDLE.
   task automatic wait_done(input logic [W-1:0] es, input logic ec, input logic eo);
      int n = 1;
      logic stable = 1'b1;
      logic [W-1:0] bad = '0;
      while (!done && n < 30) begin
         if (sum !== last_sum && stable) begin
            stable = 1'b0;
            bad = sum;
         end
         tick();
         n++;
      end
      chk("sum_hold_in_run", stable ? last_sum : bad, last_sum);
      chk("done_latency", n, 9);
      chk("sum", sum, es);
      chk("cout", cout, ec);
      chk("ovf", ovf, eo);
      last_sum = es;
      tick();
      chk("done_pulse_end", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_fa", {fa_a, fa_b, fa_cin}, 0);
   endtask

   task automatic run_op(input vec_t v);
      a = v.a; b = v.b; cin = v.cin; sub = v.sub;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_accept", busy, 1);
      wait_done(v.exp_sum, v.exp_cout, v.exp_ovf);
   endtask

   initial begin
      int ndone, adj, t0, t1, t2;
      logic pd;

      vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
      vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vecs[5] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

      // Reset state
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout_ovf", {cout, ovf}, 0);
      chk("rst_fa", {fa_a, fa_b, fa_cin}, 0);
      rst_n = 1'b1;
      tick(); tick();

      foreach (vecs[i]) run_op(vecs[i]);

      // Start pulsed during RUN with other operands must be ignored
      a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      ndone = 0;
      for (int i = 1; i <= 14; i++) begin
         if (done) begin
            ndone++;
            chk("ignored_start_sum", sum, 8'h46);
         end
         if (i == 3) begin
            a = 8'hFF; b = 8'hFF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         tick();
      end
      chk("ignored_start_done_count", ndone, 1);
      chk("ignored_start_idle", busy, 0);
      last_sum = 8'h46;

      // Reset in the middle of RUN aborts; start held across release is not
      // taken on the first edge after release
      a = 8'h5A; b = 8'h33; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout_ovf", {cout, ovf}, 0);
      chk("abort_fa", {fa_a, fa_b, fa_cin}, 0);
      last_sum = '0;
      tick();
      a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
      start = 1'b1;
      rst_n = 1'b1;
      tick();
      chk("release_edge_ignores_start", busy, 0);
      tick();
      start = 1'b0;
      chk("first_start_after_reset", busy, 1);
      wait_done(8'h02, 1'b0, 1'b0);

      // Start held high: one op every W+2 cycles, single-cycle done each
      a = 8'h03; b = 8'h04; cin = 1'b0; sub = 1'b0;
      start = 1'b1;
      ndone = 0; adj = 0; pd = 1'b0; t0 = 0; t1 = 0; t2 = 0;
      for (int i = 0; i < 45 && ndone < 3; i++) begin
         tick();
         if (done && pd) adj++;
         if (done) begin
            if (ndone == 0) t0 = cyc;
            if (ndone == 1) t1 = cyc;
            if (ndone == 2) t2 = cyc;
            ndone++;
            chk("held_start_sum", sum, 8'h07);
         end
         pd = done;
      end
      start = 1'b0;
      chk("held_start_done_count", ndone, 3);
      chk("held_start_period_1", t1 - t0, W + 2);
      chk("held_start_period_2", t2 - t1, W + 2);
      tick();
      chk("held_start_pulse_width", {adj[7:0], done}, 0);
      chk("held_start_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
